// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with hold-time preemption and a one-cycle
// break-before-make gap between grants. Define RR_LOCK_EN to add the lock input.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CW       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       busy
`ifdef RR_LOCK_EN
    ,
    input  logic       lock
`endif
);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    state_t        state;
    logic [1:0]    ptr;
    logic [CW-1:0] hold_cnt;
    logic [2:0]    win;
    logic          own_req;
    logic          rivals;
    logic          hold_full;
    logic          lock_hold;

    // Returns {found, index} of the first set request at or after p, wrapping.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign win       = pick(req, ptr);
    assign own_req   = req[gnt_id];
    assign rivals    = |(req & ~(4'b0001 << gnt_id));
    assign hold_full = (hold_cnt == HOLD_MAX);
`ifdef RR_LOCK_EN
    assign lock_hold = lock;
`else
    assign lock_hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            hold_cnt  <= '0;
            gnt       <= 4'b0000;
            gnt_id    <= 2'd0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, GAP: begin
                    if (win[2]) begin
                        state     <= GRANT;
                        gnt_id    <= win[1:0];
                        gnt       <= 4'b0001 << win[1:0];
                        gnt_valid <= 1'b1;
                        hold_cnt  <= CW'(1);
                        busy      <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GRANT: begin
                    // Release and preempt share one path; rotation starts after the owner.
                    if (!own_req || (hold_full && rivals && !lock_hold)) begin
                        state     <= GAP;
                        gnt       <= 4'b0000;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_id + 2'd1;
                    end else if (!hold_full) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= 4'b0000;
                    gnt_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: two instances (MAX_HOLD=8 and 2), directed vector
// table, hand-written corner sequences and a random run against a reference model.
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic       lock_sig = 1'b0;
    logic [3:0] gnt8, gnt2;
    logic [1:0] id8, id2;
    logic       v8, v2, b8, b2;

    int n_checks = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_arbiter4 #(.MAX_HOLD(8), .CW(8)) u_h8 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt8), .gnt_id(id8), .gnt_valid(v8), .busy(b8)
`ifdef RR_LOCK_EN
        , .lock(lock_sig)
`endif
    );

    rr_arbiter4 #(.MAX_HOLD(2), .CW(4)) u_h2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .gnt(gnt2), .gnt_id(id2), .gnt_valid(v2), .busy(b2)
`ifdef RR_LOCK_EN
        , .lock(lock_sig)
`endif
    );

    // Reference model: owner = -1 when nothing is granted.
    int m_owner[2];
    int m_held[2];
    int m_ptr[2];
    int m_last[2];
    bit m_gap[2];
    int m_max[2] = '{8, 2};

    function automatic int winner(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1; m_held[m] = 0; m_ptr[m] = 0; m_last[m] = 0; m_gap[m] = 0;
        end
    endtask

    task automatic model_edge(input logic [3:0] r, input logic lk);
        int w;
        bit others;
        for (int m = 0; m < 2; m++) begin
            if (m_owner[m] >= 0) begin
                others = (r & ~(4'b0001 << m_owner[m])) != 4'b0000;
                if (!r[m_owner[m]] || (m_held[m] >= m_max[m] && others && !lk)) begin
                    m_ptr[m] = (m_owner[m] + 1) % 4;
                    m_owner[m] = -1;
                    m_gap[m] = 1;
                end else begin
                    m_held[m]++;
                end
            end else begin
                m_gap[m] = 0;
                w = winner(r, m_ptr[m]);
                if (w >= 0) begin
                    m_owner[m] = w; m_held[m] = 1; m_last[m] = w;
                end
            end
        end
    endtask

    function automatic logic [7:0] expv(input int m);
        logic [3:0] g;
        logic       v;
        v = (m_owner[m] >= 0);
        g = v ? 4'(1 << m_last[m]) : 4'b0000;
        return {g, 2'(m_last[m]), v, (v || m_gap[m])};
    endfunction

    function automatic logic [7:0] act(input int m);
        return (m == 0) ? {gnt8, id8, v8, b8} : {gnt2, id2, v2, b2};
    endfunction

    task automatic check(input string name, input logic [7:0] a, input logic [7:0] e);
        n_checks++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, a, e);
        end
    endtask

    task automatic step(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_edge(r, lock_sig);
        @(negedge clk);
        check("model_h8", act(0), expv(0));
        check("model_h2", act(1), expv(1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 4'b0000;
        lock_sig = 1'b0;
        model_reset();
        #1;
        check("reset_h8", act(0), 8'h00);
        check("reset_h2", act(1), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [3:0] g8;
        logic       b8;
        logic [3:0] g2;
    } vec_t;

    vec_t tbl[$];
    logic [3:0] r;

    initial begin
        // Held 0110 then drop; held 1111 then drop.
        tbl.push_back('{1'b1, 4'b0110, 4'b0010, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 4'b0110, 4'b0010, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 4'b0110, 4'b0010, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 4'b0110, 4'b0010, 1'b1, 4'b0100});
        tbl.push_back('{1'b0, 4'b0110, 4'b0010, 1'b1, 4'b0100});
        tbl.push_back('{1'b0, 4'b0110, 4'b0010, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 4'b0110, 4'b0010, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 4'b0110, 4'b0010, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 4'b0110, 4'b0000, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 4'b0110, 4'b0100, 1'b1, 4'b0100});
        tbl.push_back('{1'b0, 4'b0110, 4'b0100, 1'b1, 4'b0100});
        tbl.push_back('{1'b0, 4'b0110, 4'b0100, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001, 1'b1, 4'b0001});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 4'b0001});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 4'b0010});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 4'b0100});
        tbl.push_back('{1'b0, 4'b1111, 4'b0001, 1'b1, 4'b0100});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0010, 1'b1, 4'b1000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0010, 1'b1, 4'b1000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0010, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0010, 1'b1, 4'b0001});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000});

        model_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            step(tbl[i].req);
            check("tbl_gnt_h8", {4'b0000, gnt8}, {4'b0000, tbl[i].g8});
            check("tbl_busy_h8", {7'b0, b8}, {7'b0, tbl[i].b8});
            check("tbl_gnt_h2", {4'b0000, gnt2}, {4'b0000, tbl[i].g2});
        end

        // Single persistent requester is never preempted; drop takes two edges to idle.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(4'b1000);
            check("solo_h8", {4'b0000, gnt8}, 8'h08);
            check("solo_h2", {4'b0000, gnt2}, 8'h08);
        end
        step(4'b0000);
        check("solo_drop_gap", {6'b0, v2, b2}, 8'h01);
        step(4'b0000);
        check("solo_drop_idle", {gnt2, 2'b00, v2, b2}, 8'h00);

        // Release by requester 1 moves ptr to 2; search wraps past 2,3 to 0.
        do_reset();
        step(4'b0010);
        check("wrap_first", {4'b0000, gnt8}, 8'h02);
        step(4'b0001);
        check("wrap_gap", {4'b0000, gnt8}, 8'h00);
        step(4'b0001);
        check("wrap_grant0", {4'b0000, gnt8}, 8'h01);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        step(4'b0100);
        step(4'b0100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_h8", act(0), 8'h00);
        check("async_rst_h2", act(1), 8'h00);
        model_reset();
        req = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1000);
        check("after_rst", {4'b0000, gnt8}, 8'h08);

`ifdef RR_LOCK_EN
        do_reset();
        step(4'b0011);
        lock_sig = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(4'b0011);
            check("lock_hold", {4'b0000, gnt2}, 8'h01);
        end
        lock_sig = 1'b0;
        step(4'b0011);
        check("lock_gap", {4'b0000, gnt2}, 8'h00);
        step(4'b0011);
        check("lock_next", {4'b0000, gnt2}, 8'h02);
`endif

        // Random traffic: requests change occasionally so grants can mature.
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
`ifdef RR_LOCK_EN
            lock_sig = ($urandom_range(0, 4) == 0);
`endif
            step(r);
            check("onehot_h8", {4'b0000, gnt8}, v8 ? 8'(4'b0001 << id8) : 8'h00);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
